// File: rtl/wptr_full_prog.sv
// Write-domain pointer and status generator for the asynchronous FIFO.
// Owns the binary/Gray write pointer and registers full, almost-full, level, peak and overflow.
module wptr_full_prog #(
  parameter int AddrWidth = 4
) (
  input  logic                 wclk,
  input  logic                 wrst,
  input  logic                 winc,
  input  logic [AddrWidth:0]   wq2_rgray,
  input  logic [AddrWidth:0]   afull_thresh,
  input  logic                 wclr_stat,
  output logic [AddrWidth-1:0] waddr,
  output logic [AddrWidth:0]   wgray,
  output logic                 wfull,
  output logic                 walmost_full,
  output logic [AddrWidth:0]   wlevel,
  output logic [AddrWidth:0]   wpeak,
  output logic                 woverflow
);

  logic [AddrWidth:0] wbin;
  logic [AddrWidth:0] wbin_next;
  logic [AddrWidth:0] wgray_next;
  logic [AddrWidth:0] rbin;
  logic [AddrWidth:0] level_next;
  logic [AddrWidth:0] peak_next;
  logic [AddrWidth:0] full_gray;
  logic               wpush;
  logic               wfull_next;

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= AddrWidth; i++) begin
      rbin[i] = ^(wq2_rgray >> i);
    end
  end

  assign wpush      = winc & ~wfull;
  assign wbin_next  = wbin + {{AddrWidth{1'b0}}, wpush};
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;
  assign level_next = wbin_next - rbin;
  assign full_gray  = {~wq2_rgray[AddrWidth:AddrWidth-1], wq2_rgray[AddrWidth-2:0]};
  assign wfull_next = (wgray_next == full_gray);
  assign peak_next  = (wclr_stat || (level_next > wpeak)) ? level_next : wpeak;
  assign waddr      = wbin[AddrWidth-1:0];

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin         <= '0;
      wgray        <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
      wpeak        <= '0;
      woverflow    <= 1'b0;
    end else begin
      wbin         <= wbin_next;
      wgray        <= wgray_next;
      wfull        <= wfull_next;
      walmost_full <= (level_next >= afull_thresh);
      wlevel       <= level_next;
      wpeak        <= peak_next;
      // A dropped push in the same cycle as a clear keeps the flag set.
      woverflow    <= (winc & wfull) | (woverflow & ~wclr_stat);
    end
  end

endmodule

// File: tb/tb_wptr_full_prog.sv
// Scoreboard bench for wptr_full_prog (AddrWidth=3): the driver pushes expected
// post-edge outputs from a counter-based FIFO model; a monitor pops and compares.
module tb_wptr_full_prog;

  localparam int AW = 3;
  localparam int PTR_MOD = 16;
  localparam int DEPTH = 8;

  logic          wclk = 1'b0;
  logic          wrst = 1'b0;
  logic          winc = 1'b0;
  logic [AW:0]   wq2_rgray = '0;
  logic [AW:0]   afull_thresh = '0;
  logic          wclr_stat = 1'b0;
  logic [AW-1:0] waddr;
  logic [AW:0]   wgray;
  logic          wfull;
  logic          walmost_full;
  logic [AW:0]   wlevel;
  logic [AW:0]   wpeak;
  logic          woverflow;

  wptr_full_prog #(.AddrWidth(AW)) dut (
    .wclk(wclk), .wrst(wrst), .winc(winc), .wq2_rgray(wq2_rgray),
    .afull_thresh(afull_thresh), .wclr_stat(wclr_stat), .waddr(waddr),
    .wgray(wgray), .wfull(wfull), .walmost_full(walmost_full),
    .wlevel(wlevel), .wpeak(wpeak), .woverflow(woverflow)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    int waddr; int wgray; int wlevel; int wpeak;
    int wfull; int waf; int wovf; bit pushed;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  bit done = 0;

  // Model: total accepted writes and read pointer as plain counters mod 16.
  int m_wr, m_rd, m_peak, m_thresh;
  bit m_full, m_ovf;

  function automatic logic [AW:0] to_gray(input int v);
    logic [AW:0] b;
    b = v[AW:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input bit pushed);
    exp_t e;
    int lvl;
    lvl = (m_wr - m_rd + PTR_MOD) % PTR_MOD;
    e.waddr = m_wr % DEPTH;
    e.wgray = int'(to_gray(m_wr));
    e.wlevel = lvl;
    e.wpeak = m_peak;
    e.wfull = int'(m_full);
    e.waf = (lvl >= m_thresh) ? 1 : 0;
    e.wovf = int'(m_ovf);
    e.pushed = pushed;
    q.push_back(e);
  endtask

  task automatic cyc(input bit inc, input int rd_new, input bit clr);
    bit push;
    int lvl;
    @(negedge wclk);
    wrst = 1'b0;
    winc = inc;
    wclr_stat = clr;
    m_rd = rd_new % PTR_MOD;
    wq2_rgray = to_gray(m_rd);
    push = inc && !m_full;
    m_ovf = (inc && m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_wr = (m_wr + int'(push)) % PTR_MOD;
    lvl = (m_wr - m_rd + PTR_MOD) % PTR_MOD;
    m_full = (lvl == DEPTH);
    m_peak = (clr || lvl > m_peak) ? lvl : m_peak;
    push_exp(push);
  endtask

  task automatic do_reset(input int thresh);
    @(negedge wclk);
    winc = 1'b0;
    wclr_stat = 1'b0;
    wq2_rgray = '0;
    m_thresh = thresh;
    afull_thresh = thresh[AW:0];
    m_wr = 0; m_rd = 0; m_peak = 0; m_full = 0; m_ovf = 0;
    q.push_back('{0, 0, 0, 0, 0, 0, 0, 1'b0});
    wrst = 1'b1;
  endtask

  // Monitor: samples just after every clock edge and every reset assertion.
  initial begin : monitor
    logic [AW:0] prev_gray;
    exp_t e;
    prev_gray = '0;
    while (!done) begin
      @(posedge wclk or posedge wrst);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("waddr", int'(waddr), e.waddr);
        chk("wgray", int'(wgray), e.wgray);
        chk("wlevel", int'(wlevel), e.wlevel);
        chk("wpeak", int'(wpeak), e.wpeak);
        chk("wfull", int'(wfull), e.wfull);
        chk("walmost_full", int'(walmost_full), e.waf);
        chk("woverflow", int'(woverflow), e.wovf);
        if (e.pushed) chk("gray_one_bit_step", $countones(wgray ^ prev_gray), 1);
      end
      prev_gray = wgray;
    end
  end

  initial begin : driver
    int rd_n;
    // Fill to full with a threshold that can never be reached.
    do_reset(9);
    for (int i = 0; i < 8; i++) cyc(1'b1, 0, 1'b0);
    cyc(1'b0, 0, 1'b0);
    cyc(1'b1, 0, 1'b0);          // dropped push sets overflow
    cyc(1'b0, 0, 1'b1);          // clear: overflow 0, peak = level
    cyc(1'b1, 0, 1'b1);          // clear and overflow together: set wins
    cyc(1'b0, 1, 1'b0);          // release one entry
    cyc(1'b1, 1, 1'b0);          // refill

    // Almost-full threshold 6.
    do_reset(6);
    for (int i = 0; i < 6; i++) cyc(1'b1, 0, 1'b0);
    cyc(1'b0, 0, 1'b0);
    cyc(1'b0, 1, 1'b0);
    cyc(1'b0, 1, 1'b0);

    // Threshold 0 asserts from the first clock.
    do_reset(0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 0, 1'b0);

    // Wrap with the read pointer one step behind.
    do_reset(9);
    cyc(1'b1, 0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      rd_n = (m_wr - int'($urandom_range(0, 1)) + PTR_MOD) % PTR_MOD;
      cyc(1'b1, rd_n, 1'b0);
    end

    // Random traffic with a legal, monotonic read pointer.
    do_reset(int'($urandom_range(0, 10)));
    for (int i = 0; i < 300; i++) begin
      rd_n = m_rd;
      if ($urandom_range(0, 2) == 0)
        rd_n = m_rd + int'($urandom_range(0, (m_wr - m_rd + PTR_MOD) % PTR_MOD));
      cyc(1'($urandom_range(0, 1)), rd_n, ($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset mid-stream at level 5.
    do_reset(4);
    for (int i = 0; i < 5; i++) cyc(1'b1, 0, 1'b0);
    do_reset(4);
    cyc(1'b0, 0, 1'b0);
    cyc(1'b1, 0, 1'b0);

    repeat (3) @(posedge wclk);
    #2;
    chk("scoreboard_drained", q.size(), 0);
    done = 1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

endmodule
